// File: rtl/cgra_strm_echo.sv
// CGRA-side loopback endpoint for the GLB streaming interface.
// Each lane buffers incoming g2f words in its own FIFO. A start pulse
// replays a configured number of words on every enabled lane back to f2g.
module cgra_strm_echo #(
    parameter int unsigned CGRA_PER_GLB    = 16,
    parameter int unsigned CGRA_DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          strm_start_pulse,
    input  logic [CGRA_PER_GLB-1:0][CGRA_DATA_WIDTH-1:0]  data_g2f,
    input  logic [CGRA_PER_GLB-1:0]                       data_valid_g2f,
    output logic [CGRA_PER_GLB-1:0][CGRA_DATA_WIDTH-1:0]  data_f2g,
    output logic [CGRA_PER_GLB-1:0]                       data_valid_f2g,
    input  logic [CGRA_PER_GLB-1:0]                       cfg_lane_en,
    input  logic [CNT_WIDTH-1:0]                          cfg_num_words,
    output logic                                          strm_done_pulse,
    output logic                                          busy,
    output logic [CGRA_PER_GLB-1:0]                       overflow_err,
    input  logic                                          clr_err
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]                 state_q;
    logic [0:0]                 state_d;
    logic                       done_d;
    logic                       start_c;

    logic [CGRA_PER_GLB-1:0]    en_q;
    logic [CNT_WIDTH-1:0]       target_q;
    logic [CNT_WIDTH-1:0]       sent_q   [CGRA_PER_GLB];
    logic [PW-1:0]              wr_ptr_q [CGRA_PER_GLB];
    logic [PW-1:0]              rd_ptr_q [CGRA_PER_GLB];
    logic [CGRA_DATA_WIDTH-1:0] mem_q    [CGRA_PER_GLB][FIFO_DEPTH];

    logic [CGRA_PER_GLB-1:0]    empty_c;
    logic [CGRA_PER_GLB-1:0]    full_c;
    logic [CGRA_PER_GLB-1:0]    pop_c;
    logic [CGRA_PER_GLB-1:0]    push_c;
    logic [CGRA_PER_GLB-1:0]    ovf_c;
    logic [CGRA_PER_GLB-1:0]    cpl_c;

    assign start_c = (state_q == S_IDLE) && strm_start_pulse;

    // Per-lane FIFO status, pop/push decisions and completion after this cycle's pop
    always_comb begin
        empty_c = '0;
        full_c  = '0;
        pop_c   = '0;
        push_c  = '0;
        ovf_c   = '0;
        cpl_c   = '0;
        for (int i = 0; i < CGRA_PER_GLB; i++) begin
            empty_c[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
            full_c[i]  = (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]) &&
                         (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]);
            pop_c[i]   = (state_q == S_RUN) && en_q[i] && !empty_c[i] &&
                         (sent_q[i] < target_q);
            push_c[i]  = data_valid_g2f[i] && (!full_c[i] || pop_c[i]);
            ovf_c[i]   = data_valid_g2f[i] && full_c[i] && !pop_c[i];
            cpl_c[i]   = !en_q[i] ||
                         ((sent_q[i] + CNT_WIDTH'(pop_c[i])) == target_q);
        end
    end

    // Next-state and done decision
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (strm_start_pulse) begin
                    if ((cfg_num_words == '0) || (cfg_lane_en == '0)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (&cpl_c) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state, status outputs and replay configuration
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            busy            <= 1'b0;
            strm_done_pulse <= 1'b0;
            en_q            <= '0;
            target_q        <= '0;
        end else begin
            state_q         <= state_d;
            busy            <= (state_d == S_RUN);
            strm_done_pulse <= done_d;
            if (start_c) begin
                en_q     <= cfg_lane_en;
                target_q <= cfg_num_words;
            end
        end
    end

    // Lane pointers, sent counters, output beats and sticky overflow flags
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CGRA_PER_GLB; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                sent_q[i]   <= '0;
            end
            data_f2g       <= '0;
            data_valid_f2g <= '0;
            overflow_err   <= '0;
        end else begin
            for (int i = 0; i < CGRA_PER_GLB; i++) begin
                if (push_c[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
                end
                if (pop_c[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
                    data_f2g[i] <= mem_q[i][rd_ptr_q[i][AW-1:0]];
                end
                if (start_c) begin
                    sent_q[i] <= '0;
                end else if (pop_c[i]) begin
                    sent_q[i] <= sent_q[i] + CNT_WIDTH'(1);
                end
            end
            data_valid_f2g <= pop_c;
            overflow_err   <= (overflow_err & ~{CGRA_PER_GLB{clr_err}}) | ovf_c;
        end
    end

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        for (int i = 0; i < CGRA_PER_GLB; i++) begin
            if (push_c[i]) begin
                mem_q[i][wr_ptr_q[i][AW-1:0]] <= data_g2f[i];
            end
        end
    end

endmodule
